// File: rtl/seven_seg_reader.sv
// seven_seg_reader
//   Reads an active-low single-digit seven-segment pattern back into a 4-bit
//   digit. The segment bus is filtered until it has been stable for
//   STABLE_CYCLES consecutive samples. The stable pattern is then classified,
//   and each new digit is offered once on a valid/ready output.
//
//   Optional feature macro: SEVEN_SEG_READER_HEX_EN
//     defined   -> the hex letter patterns A,b,C,d,E,F also decode legally
//     undefined -> those six patterns report out=4'hF, out_error=1
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   seg[6:0]   in   observed segments, active-low, bit0=a ... bit6=g
//   out[3:0]   out  decoded digit (4'hF when out_error=1)
//   out_error  out  pattern is outside the legal set
//   out_valid  out  out/out_error hold a report
//   out_ready  in   downstream accepts the report
//   state_dbg  out  FSM state (0=SETTLE, 1=REPORT)
//
// Handshake: a report transfers on any rising edge where out_valid and
// out_ready are both 1. out_valid never drops without that transfer, and
// out/out_error change only while out_valid=0. out_ready never reaches
// out_valid combinationally.

module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] out,
    output logic       out_error,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       state_dbg
);

    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [6:0]      BLANK   = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t        state;
    logic [6:0]    seg_q;
    logic [CW-1:0] cnt;
    logic [6:0]    last_code;
    logic          stable;
    logic [4:0]    dec;

    // Returns {illegal, digit}.
    function automatic logic [4:0] decode(input logic [6:0] code);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        case (code)
            7'h40: r = {1'b0, 4'h0};
            7'h79: r = {1'b0, 4'h1};
            7'h24: r = {1'b0, 4'h2};
            7'h30: r = {1'b0, 4'h3};
            7'h19: r = {1'b0, 4'h4};
            7'h12: r = {1'b0, 4'h5};
            7'h02: r = {1'b0, 4'h6};
            7'h78: r = {1'b0, 4'h7};
            7'h00: r = {1'b0, 4'h8};
            7'h10: r = {1'b0, 4'h9};
`ifdef SEVEN_SEG_READER_HEX_EN
            7'h08: r = {1'b0, 4'hA};
            7'h03: r = {1'b0, 4'hB};
            7'h46: r = {1'b0, 4'hC};
            7'h21: r = {1'b0, 4'hD};
            7'h06: r = {1'b0, 4'hE};
            7'h0E: r = {1'b0, 4'hF};
`endif
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    assign stable    = (cnt == CNT_MAX);
    assign dec       = decode(seg_q);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q     <= BLANK;
            cnt       <= '0;
            last_code <= BLANK;
            out       <= 4'h0;
            out_error <= 1'b0;
            out_valid <= 1'b0;
            state     <= SETTLE;
        end else begin
            // The filter keeps running in both states so that the pattern
            // present when SETTLE is re-entered is judged immediately.
            seg_q <= seg;
            if (seg != seg_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                SETTLE: begin
                    if (stable && seg_q == BLANK) begin
                        // A stable blank re-arms reporting of the same digit.
                        last_code <= BLANK;
                    end else if (stable && seg_q != last_code) begin
                        last_code <= seg_q;
                        out       <= dec[3:0];
                        out_error <= dec[4];
                        out_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
module tb_seven_seg_reader;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] out;
    logic       out_error;
    logic       out_valid;
    logic       out_ready;
    logic       state_dbg;

    int total = 0;
    int bad   = 0;

    seven_seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .out       (out),
        .out_error (out_error),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Digit n is the position of its pattern in this table.
    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        int n;
`ifdef SEVEN_SEG_READER_HEX_EN
        n = 16;
`else
        n = 10;
`endif
        for (int i = 0; i < n; i++)
            if (codes[i] == s) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    // Model state: the current run of identical seg samples (a reset counts
    // as one sample of blank), plus the pending report and last code.
    logic       model_ok = 1'b0;
    logic       m_valid;
    logic [3:0] m_out;
    logic       m_err;
    logic [6:0] m_last;
    logic [6:0] run_val;
    int         run_len;
    logic [4:0] got_q[$];   // accepted reports {out_error, out}

    always @(posedge clk) begin
        logic       st;
        logic [4:0] d;
        if (rst_n && out_valid && out_ready) got_q.push_back({out_error, out});
        if (!rst_n) begin
            model_ok = 1'b1;
            m_valid  = 1'b0;
            m_out    = 4'h0;
            m_err    = 1'b0;
            m_last   = 7'h7F;
            run_val  = 7'h7F;
            run_len  = 1;
        end else begin
            st = (run_len > S);   // S+1 equal samples seen before this edge
            if (m_valid) begin
                if (out_ready) m_valid = 1'b0;
            end else if (st && run_val == 7'h7F) begin
                m_last = 7'h7F;
            end else if (st && run_val != m_last) begin
                m_last  = run_val;
                d       = model_decode(run_val);
                m_out   = d[3:0];
                m_err   = d[4];
                m_valid = 1'b1;
            end
            if (seg == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = seg;
                run_len = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_valid", int'(out_valid), int'(m_valid));
            check("model_out",   int'(out),       int'(m_out));
            check("model_err",   int'(out_error), int'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [6:0] s, input int n);
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, int'(out_valid), 1);
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] pool [12] = '{7'h7F, 7'h7F, 7'h40, 7'h79, 7'h24, 7'h12,
                              7'h78, 7'h10, 7'h08, 7'h46, 7'h55, 7'h7F};

    initial begin
        int n;
        rst_n = 1'b0; seg = 7'h12; out_ready = 1'b0;

        // Reset then first report latency.
        repeat (2) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_out",   int'(out),       0);
        check("rst_err",   int'(out_error), 0);
        rst_n = 1'b1; out_ready = 1'b1;
        wait_valid("first", 20, n);
        check("first_latency", n, S + 2);
        check("first_out", int'(out), 5);
        @(negedge clk);
        check("first_one_cycle", int'(out_valid), 0);

        // Glitch shorter than the filter is ignored.
        hold(7'h7F, 8);
        got_q.delete();
        hold(7'h30, 3);
        hold(7'h7F, 8);
        check("glitch_none", got_q.size(), 0);
        hold(7'h30, 10);
        check("glitch_count", got_q.size(), 1);
        if (got_q.size() > 0) check("glitch_out", int'(got_q[0]), 3);

        // Backpressure: changes during REPORT are not queued.
        out_ready = 1'b0;
        seg = 7'h24;
        wait_valid("bp", 20, n);
        check("bp_out", int'(out), 2);
        hold(7'h19, 6);
        hold(7'h00, 6);
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_out",   int'(out),       2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_drop", int'(out_valid), 0);
        wait_valid("bp_next", 5, n);
        check("bp_next_lat", n, 1);
        check("bp_next_out", int'(out), 8);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Repeat digits need a blank between them.
        got_q.delete();
        hold(7'h7F, 8);
        hold(7'h78, 8);
        hold(7'h7F, 8);
        hold(7'h78, 8);
        check("rep_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("rep_a", int'(got_q[0]), 7);
            check("rep_b", int'(got_q[1]), 7);
        end
        got_q.delete();
        hold(7'h7F, 8);
        hold(7'h78, 20);
        check("rep_once", got_q.size(), 1);

        // Illegal and optional hex patterns.
        out_ready = 1'b0;
        seg = 7'h08;
        wait_valid("hex", 20, n);
`ifdef SEVEN_SEG_READER_HEX_EN
        check("hex_out", int'(out), 10);
        check("hex_err", int'(out_error), 0);
`else
        check("hex_out", int'(out), 15);
        check("hex_err", int'(out_error), 1);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        seg = 7'h55;
        wait_valid("ill", 20, n);
        check("ill_out", int'(out), 15);
        check("ill_err", int'(out_error), 1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during a pending report.
        out_ready = 1'b0;
        seg = 7'h02;
        wait_valid("mid", 20, n);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        wait_valid("mid_again", 20, n);
        check("mid_latency", n, S + 2);
        check("mid_out", int'(out), 6);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Random traffic against the model.
        for (int it = 0; it < 120; it++) begin
            int len;
            logic [6:0] s;
            s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pool[$urandom_range(0, 11)];
            len = $urandom_range(1, 9);
            seg = s;
            for (int c = 0; c < len; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                rst_n = ($urandom_range(0, 60) != 0);
                @(negedge clk);
            end
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
